// File: rtl/evr_v1_dbuff_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : evr_v1_dbuff_reader                                              |
// | Brief   : Arms the EVR data-buffer decoder, reads each finished frame and  |
// |           emits it as a 32-bit valid/ready stream with SOF/EOF/keep/err.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module evr_v1_dbuff_reader #(
  parameter int ENA_HOLD = 4,
  parameter int DROP_BAD = 0
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        enable,
  input  logic        dbrdy,
  input  logic        dbcs,
  input  logic [11:0] rxSize,
  input  logic [31:0] dataBuffOut,
  output logic        dben,
  output logic        dbena,
  output logic [8:0]  dbRdAddr,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_sof,
  output logic        m_eof,
  output logic        m_err,
  output logic [15:0] frameCnt,
  output logic [15:0] errCnt,
  output logic        busy
);

  localparam int HOLD_W = (ENA_HOLD > 2) ? $clog2(ENA_HOLD) : 1;
  localparam logic [HOLD_W-1:0] c_HOLD_INIT = HOLD_W'(ENA_HOLD - 1);

  localparam logic [2:0] c_ST_DISABLED = 3'd0;
  localparam logic [2:0] c_ST_ARM      = 3'd1;
  localparam logic [2:0] c_ST_WAIT     = 3'd2;
  localparam logic [2:0] c_ST_READ     = 3'd3;
  localparam logic [2:0] c_ST_DRAIN    = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [HOLD_W-1:0] r_hold;
  logic              r_dben;
  logic [8:0]        r_addr;
  logic              r_d;
  logic [8:0]        r_d_idx;
  logic [9:0]        r_nw;
  logic [1:0]        r_rem;
  logic              r_err;
  logic              r_vld0;
  logic              r_vld1;
  logic [38:0]       r_ent0;
  logic [38:0]       r_ent1;
  logic [15:0]       r_frame_cnt;
  logic [15:0]       r_err_cnt;

  logic [11:0] w_sz;
  logic [9:0]  w_nw;
  logic        w_err_in;
  logic        w_start;
  logic        w_pop;
  logic [1:0]  w_occ;
  logic        w_credit;
  logic        w_issue;
  logic        w_addr_last;
  logic        w_cap_last;
  logic        w_drop;
  logic        w_push;
  logic        w_done;
  logic        w_frame_end;
  logic        w_frame_err;
  logic [3:0]  w_keep_last;
  logic        w_new_eof;
  logic [38:0] w_new;

  assign w_sz     = (rxSize > 12'd2048) ? 12'd2048 : rxSize;
  assign w_nw     = 10'((w_sz + 12'd3) >> 2);
  assign w_err_in = dbcs | (rxSize > 12'd2048);
  assign w_start  = (r_state == c_ST_WAIT) && enable && dbrdy;

  // Head entry of the skid FIFO drives the stream outputs directly
  assign w_pop    = r_vld0 & m_ready;
  assign w_occ    = {1'b0, r_vld0} + {1'b0, r_vld1} + {1'b0, r_d};
  // Outstanding words after this edge may not exceed the two FIFO slots
  assign w_credit = (w_occ <= ({1'b0, w_pop} + 2'd1));
  assign w_issue  = (r_state == c_ST_READ) && w_credit;

  assign w_addr_last = ({1'b0, r_addr}  == (r_nw - 10'd1));
  assign w_cap_last  = ({1'b0, r_d_idx} == (r_nw - 10'd1));

  assign w_drop = (DROP_BAD != 0) && r_err;
  assign w_push = r_d && !w_drop;

  always_comb begin
    w_keep_last = 4'b1111;
    case (r_rem)
      2'd1:    w_keep_last = 4'b1000;
      2'd2:    w_keep_last = 4'b1100;
      2'd3:    w_keep_last = 4'b1110;
      default: w_keep_last = 4'b1111;
    endcase
  end

  assign w_new_eof = w_cap_last;
  assign w_new = {w_new_eof & r_err, w_new_eof, (r_d_idx == 9'd0),
                  (w_new_eof ? w_keep_last : 4'b1111), dataBuffOut};

  assign w_done = w_drop ? (r_d && w_cap_last) : (w_pop && r_ent0[37]);

  assign w_frame_end = (w_start && (w_nw == 10'd0)) ||
                       ((r_state == c_ST_DRAIN) && w_done);
  assign w_frame_err = (r_state == c_ST_WAIT) ? w_err_in : r_err;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= c_ST_DISABLED;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_ST_DISABLED: if (enable) w_next = c_ST_ARM;
      c_ST_ARM: begin
        if (r_hold == '0) begin
          if (!enable)    w_next = c_ST_DISABLED;
          else if (!dbrdy) w_next = c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (!enable)    w_next = c_ST_DISABLED;
        else if (dbrdy) w_next = (w_nw == 10'd0) ? c_ST_ARM : c_ST_READ;
      end
      c_ST_READ:  if (w_issue && w_addr_last) w_next = c_ST_DRAIN;
      c_ST_DRAIN: if (w_done) w_next = enable ? c_ST_ARM : c_ST_DISABLED;
      default:    w_next = c_ST_DISABLED;
    endcase
  end

  always_comb begin
    dbena = 1'b0;
    busy  = 1'b0;
    case (r_state)
      c_ST_ARM:   dbena = 1'b1;
      c_ST_READ:  busy  = 1'b1;
      c_ST_DRAIN: busy  = 1'b1;
      default: begin
        dbena = 1'b0;
        busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_dben      <= 1'b0;
      r_hold      <= c_HOLD_INIT;
      r_addr      <= '0;
      r_d         <= 1'b0;
      r_d_idx     <= '0;
      r_nw        <= '0;
      r_rem       <= '0;
      r_err       <= 1'b0;
      r_vld0      <= 1'b0;
      r_vld1      <= 1'b0;
      r_ent0      <= '0;
      r_ent1      <= '0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_dben <= enable;

      if (r_state != c_ST_ARM) r_hold <= c_HOLD_INIT;
      else if (r_hold != '0)   r_hold <= r_hold - 1'b1;

      if (w_start) begin
        r_nw  <= w_nw;
        r_rem <= rxSize[1:0];
        r_err <= w_err_in;
      end

      if (r_state == c_ST_WAIT)        r_addr <= '0;
      else if (w_issue && !w_addr_last) r_addr <= r_addr + 9'd1;

      r_d <= w_issue;
      if (w_issue) r_d_idx <= r_addr;

      if (w_pop) begin
        if (r_vld1) begin
          r_ent0 <= r_ent1;
          r_vld1 <= w_push;
          if (w_push) r_ent1 <= w_new;
        end else if (w_push) begin
          r_ent0 <= w_new;
        end else begin
          r_vld0 <= 1'b0;
        end
      end else if (w_push) begin
        if (!r_vld0) begin
          r_vld0 <= 1'b1;
          r_ent0 <= w_new;
        end else begin
          r_vld1 <= 1'b1;
          r_ent1 <= w_new;
        end
      end

      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (w_frame_err) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign dben     = r_dben;
  assign dbRdAddr = r_addr;
  assign m_valid  = r_vld0;
  assign m_data   = r_ent0[31:0];
  assign m_keep   = r_ent0[35:32];
  assign m_sof    = r_ent0[36];
  assign m_eof    = r_ent0[37];
  assign m_err    = r_ent0[38];
  assign frameCnt = r_frame_cnt;
  assign errCnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_evr_v1_dbuff_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_evr_v1_dbuff_reader                                           |
// | Brief   : Scoreboard bench for evr_v1_dbuff_reader (DROP_BAD 0 and 1).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_evr_v1_dbuff_reader;
  localparam int ENA_HOLD = 4;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        s;
    logic        e;
    logic        r;
  } beat_t;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        ResetN, enable, dbrdy, dbcs, m_ready;
  logic [11:0] rxSize;
  logic [31:0] buf_q;
  logic        dben, dbena, m_valid, m_sof, m_eof, m_err, busy;
  logic [8:0]  dbRdAddr;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic [15:0] frameCnt, errCnt;

  logic        enable_d, dbrdy_d, dbcs_d, m_ready_d;
  logic [11:0] rxSize_d;
  logic [31:0] buf_q_d;
  logic        dben_d, dbena_d, m_valid_d, m_sof_d, m_eof_d, m_err_d, busy_d;
  logic [8:0]  dbRdAddr_d;
  logic [31:0] m_data_d;
  logic [3:0]  m_keep_d;
  logic [15:0] frameCnt_d, errCnt_d;

  evr_v1_dbuff_reader #(.ENA_HOLD(ENA_HOLD), .DROP_BAD(0)) u_dut (
    .Clock(Clock), .ResetN(ResetN), .enable(enable), .dbrdy(dbrdy), .dbcs(dbcs),
    .rxSize(rxSize), .dataBuffOut(buf_q), .dben(dben), .dbena(dbena),
    .dbRdAddr(dbRdAddr), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
    .m_ready(m_ready), .m_sof(m_sof), .m_eof(m_eof), .m_err(m_err),
    .frameCnt(frameCnt), .errCnt(errCnt), .busy(busy)
  );

  evr_v1_dbuff_reader #(.ENA_HOLD(ENA_HOLD), .DROP_BAD(1)) u_drop (
    .Clock(Clock), .ResetN(ResetN), .enable(enable_d), .dbrdy(dbrdy_d), .dbcs(dbcs_d),
    .rxSize(rxSize_d), .dataBuffOut(buf_q_d), .dben(dben_d), .dbena(dbena_d),
    .dbRdAddr(dbRdAddr_d), .m_data(m_data_d), .m_keep(m_keep_d), .m_valid(m_valid_d),
    .m_ready(m_ready_d), .m_sof(m_sof_d), .m_eof(m_eof_d), .m_err(m_err_d),
    .frameCnt(frameCnt_d), .errCnt(errCnt_d), .busy(busy_d)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Buffer model: word content encodes frame seed and address
  function automatic logic [31:0] mk_word(input logic [15:0] s, input logic [8:0] a);
    return {s, 7'd0, a};
  endfunction

  logic [15:0] seed = 16'h0;
  logic [15:0] seed_d = 16'h0;
  always @(posedge Clock) buf_q   <= mk_word(seed, dbRdAddr);
  always @(posedge Clock) buf_q_d <= mk_word(seed_d, dbRdAddr_d);

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int rmode = 0;
  int rph = 0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge Clock);
      #1;
      case (rmode)
        0: m_ready = 1'b1;
        1: begin m_ready = (rph == 0); rph = (rph + 1) % 3; end
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  beat_t q[$];
  beat_t mon_e;
  int beats_seen = 0;
  int sof_cyc = 0;
  int eof_cyc = 0;
  logic        mon_stall = 1'b0;
  logic [39:0] mon_cur, mon_prev;

  always @(negedge Clock) begin
    if (!ResetN) begin
      mon_stall = 1'b0;
    end else begin
      mon_cur = {m_valid, m_data, m_keep, m_sof, m_eof, m_err};
      if (mon_stall) check_eq("stall_hold", mon_cur, mon_prev);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          check_eq("unexpected_beat", m_valid, 0);
        end else begin
          mon_e = q.pop_front();
          check_eq("beat", {m_data, m_keep, m_sof, m_eof, m_err}, mon_e);
          beats_seen++;
          if (m_sof) sof_cyc = cyc;
          if (m_eof) eof_cyc = cyc;
        end
      end
      mon_stall = m_valid && !m_ready;
      mon_prev  = mon_cur;
    end
  end

  int exp_frames = 0;
  int exp_errs = 0;

  task automatic arm_wait(input string tag);
    int n = 0;
    while (!dbena && n < 100) begin @(negedge Clock); n++; end
    check_eq({tag, "_arm"}, dbena, 1);
    if (!dbena) return;
    dbrdy = 1'b0;
    n = 0;
    while (dbena && n < 100) begin n++; @(negedge Clock); end
    check_eq({tag, "_hold"}, n, ENA_HOLD);
  endtask

  task automatic run_frame(input string tag, input int size, input bit cs, input int drop_at);
    int sz_c, nw, n, b0;
    bit err;
    logic [1:0] rem;
    logic [3:0] kl;
    beat_t e;
    sz_c = (size > 2048) ? 2048 : size;
    nw   = (sz_c + 3) / 4;
    rem  = size[1:0];
    err  = cs || (size > 2048);
    kl   = (rem == 2'd0) ? 4'b1111 : (rem == 2'd1) ? 4'b1000 :
           (rem == 2'd2) ? 4'b1100 : 4'b1110;
    seed = 16'($urandom);
    for (int i = 0; i < nw; i++) begin
      e.d = mk_word(seed, 9'(i));
      e.s = (i == 0);
      e.e = (i == nw - 1);
      e.k = e.e ? kl : 4'b1111;
      e.r = e.e & err;
      q.push_back(e);
    end
    exp_frames++;
    if (err) exp_errs++;
    b0 = beats_seen;
    rxSize = 12'(size);
    dbcs   = cs;
    dbrdy  = 1'b1;
    n = 0;
    while (frameCnt != exp_frames[15:0] && n < 4000) begin
      @(negedge Clock);
      n++;
      if (drop_at >= 0 && enable && (beats_seen - b0) >= drop_at) begin
        enable = 1'b0;
        #1;
        check_eq({tag, "_dben_hold"}, dben, 1);
        @(negedge Clock);
        n++;
        check_eq({tag, "_dben_fall"}, dben, 0);
      end
    end
    check_eq({tag, "_frames"}, frameCnt, exp_frames[15:0]);
    check_eq({tag, "_errs"}, errCnt, exp_errs[15:0]);
    check_eq({tag, "_beats"}, beats_seen - b0, nw);
    check_eq({tag, "_qempty"}, q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, vcnt;
    bit seen;
    ResetN = 1'b0; enable = 1'b0; dbrdy = 1'b0; dbcs = 1'b0; rxSize = '0;
    enable_d = 1'b0; dbrdy_d = 1'b0; dbcs_d = 1'b0; rxSize_d = '0; m_ready_d = 1'b1;
    repeat (3) @(negedge Clock);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dbena", dbena, 0);
    check_eq("rst_dben", dben, 0);
    check_eq("rst_frameCnt", frameCnt, 0);
    check_eq("rst_errCnt", errCnt, 0);
    ResetN = 1'b1;
    enable = 1'b1;

    arm_wait("a0");
    rmode = 0; run_frame("f9", 9, 1'b0, -1);
    arm_wait("a1");
    rmode = 1; run_frame("bp64", 64, 1'b0, -1);
    arm_wait("a2");
    rmode = 0; run_frame("thr64", 64, 1'b0, -1);
    check_eq("thr64_consecutive", eof_cyc - sof_cyc, 15);
    arm_wait("a3");
    run_frame("cs4", 4, 1'b1, -1);
    arm_wait("a4");
    run_frame("zero", 0, 1'b0, -1);
    arm_wait("a5");
    rmode = 2; run_frame("big2049", 2049, 1'b0, -1);
    arm_wait("a6");
    rmode = 0; run_frame("endrop", 40, 1'b0, 3);
    dbrdy = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge Clock); if (dbena || busy) seen = 1'b1; end
    check_eq("disabled_quiet", seen, 0);
    enable = 1'b1;
    arm_wait("a7");

    // DROP_BAD=1 instance: checksum-errored frame is read but never emitted
    enable_d = 1'b1;
    n = 0;
    while (!dbena_d && n < 50) begin @(negedge Clock); n++; end
    check_eq("drop_arm", dbena_d, 1);
    n = 0;
    while (dbena_d && n < 50) begin n++; @(negedge Clock); end
    check_eq("drop_hold", n, ENA_HOLD);
    seed_d = 16'h5A5A; rxSize_d = 12'd4; dbcs_d = 1'b1; dbrdy_d = 1'b1;
    vcnt = 0; seen = 1'b0;
    repeat (30) begin
      @(negedge Clock);
      if (m_valid_d) vcnt++;
      if (busy_d) seen = 1'b1;
    end
    check_eq("drop_no_valid", vcnt, 0);
    check_eq("drop_read_done", seen, 1);
    check_eq("drop_frameCnt", frameCnt_d, 1);
    check_eq("drop_errCnt", errCnt_d, 1);
    enable_d = 1'b0;

    // Reset while a stalled frame is being read
    rmode = 3;
    seed = 16'h1234; rxSize = 12'd64; dbcs = 1'b0; dbrdy = 1'b1;
    n = 0;
    while (!busy && n < 50) begin @(negedge Clock); n++; end
    repeat (3) @(negedge Clock);
    check_eq("pre_rst_busy", busy, 1);
    check_eq("pre_rst_valid", m_valid, 1);
    ResetN = 1'b0;
    #1;
    check_eq("mid_rst_m_valid", m_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_dbena", dbena, 0);
    check_eq("mid_rst_frameCnt", frameCnt, 0);
    check_eq("mid_rst_errCnt", errCnt, 0);
    dbrdy = 1'b0;
    exp_frames = 0;
    exp_errs = 0;
    q.delete();
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    rmode = 0;
    arm_wait("a_rst");
    run_frame("post_rst", 9, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
